// File: rtl/div8by4_seq.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Handshake: a start pulse sampled in IDLE launches one operation, and done pulses once when the results update.
module div8by4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       div0,
  output logic [7:0] quotient,
  output logic [3:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] prem;
  logic [7:0] sreg;
  logic [3:0] dvsr;
  logic [2:0] count;

  logic [5:0] shifted;
  logic [5:0] trial;
  logic       fits;
  logic [4:0] next_prem;
  logic [7:0] next_sreg;

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  always_comb begin
    shifted   = {prem, sreg[7]};
    trial     = shifted - {2'b00, dvsr};
    fits      = ~trial[5];
    next_prem = fits ? trial[4:0] : shifted[4:0];
    next_sreg = {sreg[6:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 4'h0;
      prem      <= 5'd0;
      sreg      <= 8'h00;
      dvsr      <= 4'h0;
      count     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor != 4'h0) begin
              dvsr  <= divisor;
              prem  <= 5'd0;
              sreg  <= dividend;
              count <= 3'd0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              quotient  <= 8'hFF;
              remainder <= 4'h0;
              div0      <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          prem  <= next_prem;
          sreg  <= next_sreg;
          count <= count + 3'd1;
          // Eighth step: publish results, dropping busy as done rises.
          if (count == 3'd7) begin
            quotient  <= next_sreg;
            remainder <= next_prem[3:0];
            div0      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
